// File: rtl/axis_crc32_engine_pkg.sv
// axis_crc32_engine_pkg: shared CRC-32 constants and the reflected byte-step function
package axis_crc32_engine_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'h2144DF1C;
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ CRC32_POLY_REFL : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/axis_crc32_engine_byte_step.sv
// crc32_byte_step: combinational reflected CRC-32 advance over one byte
module crc32_byte_step
  import axis_crc32_engine_pkg::*;
(
  input  logic [31:0] state_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] state_out
);
  assign state_out = crc32_byte(state_in, byte_in);
endmodule

// File: rtl/axis_crc32_engine.sv
// axis_crc32_engine: streaming Ethernet CRC-32 over AXI-Stream frames with a single registered result slot
module axis_crc32_engine
  import axis_crc32_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit CHECK      = 1'b0,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [31:0]           m_crc,
  output logic [LEN_WIDTH-1:0]  m_crc_len,
  output logic                  m_crc_ok,
  output logic                  m_crc_valid,
  input  logic                  m_crc_ready
);
  logic [31:0]          state_q, state_d, crc_q, crc_d, crc_next;
  logic [LEN_WIDTH-1:0] len_q, len_d, len_out_q, len_out_d, len_acc;
  logic [LEN_WIDTH:0]   len_sum;
  logic                 valid_q, valid_d, ok_q, ok_d, accept, last;
  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    logic [31:0] prev, stepped, cur;
    if (i == 0) begin : g_first
      assign prev = state_q;
    end else begin : g_next
      assign prev = g_lane[i-1].cur;
    end
    crc32_byte_step u_step (
      .state_in (prev),
      .byte_in  (s_axis_tdata[8*i +: 8]),
      .state_out(stepped)
    );
    assign cur = s_axis_tkeep[i] ? stepped : prev;
  end
  assign crc_next = g_lane[KEEP_WIDTH-1].cur;
  // byte count of this beat added to the running length, clamped at all-ones
  always_comb begin
    len_sum = {1'b0, len_q};
    for (int k = 0; k < KEEP_WIDTH; k++) len_sum = len_sum + {{LEN_WIDTH{1'b0}}, s_axis_tkeep[k]};
    len_acc = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
  end
  assign s_axis_tready = ~valid_q | m_crc_ready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign last          = accept & s_axis_tlast;
  // running state reloads at frame end; the result slot loads on tlast and drains on handshake
  always_comb begin
    state_d   = last ? CRC32_INIT : accept ? crc_next : state_q;
    len_d     = last ? '0 : accept ? len_acc : len_q;
    valid_d   = last | (valid_q & ~m_crc_ready);
    crc_d     = last ? ~crc_next : crc_q;
    len_out_d = last ? len_acc : len_out_q;
    ok_d      = last ? (CHECK && (~crc_next == CRC32_RESIDUE)) : ok_q;
  end
  // state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CRC32_INIT;
      len_q     <= '0;
      valid_q   <= 1'b0;
      crc_q     <= '0;
      len_out_q <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      crc_q     <= crc_d;
      len_out_q <= len_out_d;
      ok_q      <= ok_d;
    end
  end
  assign m_crc       = crc_q;
  assign m_crc_len   = len_out_q;
  assign m_crc_ok    = ok_q;
  assign m_crc_valid = valid_q;
endmodule
